io_bus_controller: RTL and testbench

Memory-mapped I/O controller between the pipelined CPU's MEM-stage data bus and the board I/O: 10 switches, 10 LEDs and 6 seven-segment digits.
- Decodes a 4-word I/O window.
- Synchronises and debounces the switches.
- Holds the LED and hex-display registers and drives the segment patterns.
- Returns read data with a registered one-cycle valid handshake, which the MEM/WB path consumes.

---
 rtl/io_bus_controller.sv | 152 +++++++++++++++
 tb/tb_io_bus_controller.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_controller.sv
// io_bus_controller: memory-mapped I/O block on the MEM-stage data bus.
// It decodes a 16-byte window at IO_BASE, debounces 10 switches and holds
// the LED and hex-display registers. Reads return data with a registered
// one-cycle valid pulse.
//
// Ports:
//   clock, reset    system clock; synchronous active-high reset
//   addr            byte address; word offset is addr[3:2]
//   rd_en, wr_en    single-cycle read and write requests
//   wdata           write data
//   is_io           combinational window hit
//   rdata, rvalid   registered read data and its one-cycle qualifier
//   sw_in           raw asynchronous switch inputs
//   led_out         LED register
//   hex_out         six active-low 7-segment digits; digit i on [7i+6:7i]
module io_bus_controller #(
    parameter logic [31:0] IO_BASE         = 32'h0000_00C0,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] wdata,
    output logic        is_io,
    output logic [31:0] rdata,
    output logic        rvalid,
    input  logic [9:0]  sw_in,
    output logic [9:0]  led_out,
    output logic [41:0] hex_out
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;

    localparam logic [1:0] REG_SW   = 2'd0;
    localparam logic [1:0] REG_LED  = 2'd1;
    localparam logic [1:0] REG_HEX  = 2'd2;
    localparam logic [1:0] REG_STAT = 2'd3;

    logic [9:0]       sync1;
    logic [9:0]       sync2;
    logic [9:0]       sw_stable;
    logic [CNT_W-1:0] cnt;
    logic             sw_changed;
    logic [9:0]       led_reg;
    logic [23:0]      hex_reg;

    logic [1:0]       word;
    logic             rd_ok;
    logic             wr_ok;
    logic             accept;
    logic [31:0]      rd_mux;

    // Byte lane and upper write bits have no destination in this map.
    logic             unused_bits;
    assign unused_bits = ^{addr[1:0], wdata[31:24]};

    assign is_io  = (addr[31:4] == IO_BASE[31:4]);
    assign word   = addr[3:2];
    // A simultaneous write wins; the read is dropped.
    assign wr_ok  = is_io && wr_en;
    assign rd_ok  = is_io && rd_en && !wr_en;
    assign accept = (sync2 != sw_stable) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    // Read mux, sampled with pre-edge register values.
    always_comb begin
        rd_mux = '0;
        case (word)
            REG_SW:   rd_mux = {22'b0, sw_stable};
            REG_LED:  rd_mux = {22'b0, led_reg};
            REG_HEX:  rd_mux = {8'b0, hex_reg};
            REG_STAT: rd_mux = {31'b0, sw_changed};
            default:  rd_mux = '0;
        endcase
    end

    // Synchroniser, debounce, bus registers and read response.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1      <= '0;
            sync2      <= '0;
            sw_stable  <= '0;
            cnt        <= '0;
            sw_changed <= 1'b0;
            led_reg    <= '0;
            hex_reg    <= '0;
            rdata      <= '0;
            rvalid     <= 1'b0;
        end else begin
            sync1 <= sw_in;
            sync2 <= sync1;

            if (sync2 == sw_stable) begin
                cnt <= '0;
            end else if (accept) begin
                sw_stable <= sync2;
                cnt       <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            // A new acceptance beats a clearing STAT read on the same edge.
            if (accept) begin
                sw_changed <= 1'b1;
            end else if (rd_ok && (word == REG_STAT)) begin
                sw_changed <= 1'b0;
            end

            if (wr_ok && (word == REG_LED)) begin
                led_reg <= wdata[9:0];
            end
            if (wr_ok && (word == REG_HEX)) begin
                hex_reg <= wdata[23:0];
            end

            rdata  <= rd_ok ? rd_mux : 32'h0;
            rvalid <= rd_ok;
        end
    end

    assign led_out = led_reg;

    // Active-low segment pattern, bit 6 = g ... bit 0 = a.
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    for (genvar i = 0; i < 6; i++) begin : g_digit
        assign hex_out[7*i +: 7] = seg7(hex_reg[4*i +: 4]);
    end

endmodule

// File: tb/tb_io_bus_controller.sv
// Directed bench for io_bus_controller: expected read data is queued as each
// read is issued and compared by a monitor when rvalid appears.
module tb_io_bus_controller;

    localparam logic [31:0] BASE     = 32'h0000_00C0;
    localparam logic [41:0] HEX_ZERO = {6{7'b1000000}};
    localparam logic [6:0]  SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic        clock;
    logic        reset;
    logic [31:0] addr;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] wdata;
    logic        is_io;
    logic [31:0] rdata;
    logic        rvalid;
    logic [9:0]  sw_in;
    logic [9:0]  led_out;
    logic [41:0] hex_out;

    int          checks;
    int          errors;
    logic [31:0] exp_q [$];

    io_bus_controller #(
        .IO_BASE         (BASE),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .addr    (addr),
        .rd_en   (rd_en),
        .wr_en   (wr_en),
        .wdata   (wdata),
        .is_io   (is_io),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .sw_in   (sw_in),
        .led_out (led_out),
        .hex_out (hex_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [41:0] hex_model(input logic [23:0] v);
        logic [41:0] h;
        for (int i = 0; i < 6; i++) h[7*i +: 7] = SEG[v[4*i +: 4]];
        return h;
    endfunction

    // Advance past one rising edge; inputs change and outputs are read here.
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp);
        addr  = a;
        rd_en = 1'b1;
        exp_q.push_back(exp);
        tick();
        rd_en = 1'b0;
    endtask

    // Scoreboard monitor: every rvalid must match the oldest queued read.
    always @(posedge clock) begin
        #1;
        if (rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rvalid", 64'(rvalid), 64'(0));
            end else begin
                check("rdata", 64'(rdata), 64'(exp_q.pop_front()));
            end
        end else begin
            check("rvalid_known", 64'(rvalid), 64'(0));
            check("rdata_idle", 64'(rdata), 64'(0));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        rd_en  = 1'b0;
        wr_en  = 1'b0;
        addr   = '0;
        wdata  = '0;
        sw_in  = '0;

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        check("reset_led", 64'(led_out), 64'(0));
        check("reset_rvalid", 64'(rvalid), 64'(0));
        check("reset_rdata", 64'(rdata), 64'(0));
        check("reset_hex", 64'(hex_out), 64'(HEX_ZERO));

        // LED write/readback and out-of-window write
        addr = BASE + 32'd4;
        #1;
        check("is_io_led", 64'(is_io), 64'(1));
        wr(BASE + 32'd4, 32'h3FF);
        check("led_3ff", 64'(led_out), 64'(10'h3FF));
        rd(BASE + 32'd4, 32'h3FF);
        addr  = BASE + 32'd16;
        wdata = 32'h0;
        wr_en = 1'b1;
        rd_en = 1'b0;
        #1;
        check("is_io_outside", 64'(is_io), 64'(0));
        tick();
        wr_en = 1'b0;
        check("led_unchanged", 64'(led_out), 64'(10'h3FF));
        rd(BASE + 32'd20, 32'h0);
        void'(exp_q.pop_back());
        tick();
        check("outside_read_no_rvalid", 64'(rvalid), 64'(0));

        // HEX write, decode and readback
        wr(BASE + 32'd8, 32'h00FF_12AB);
        check("hex_ff12ab", 64'(hex_out),
              64'({7'b0001110, 7'b0001110, 7'b1111001, 7'b0100100, 7'b0001000, 7'b0000011}));
        rd(BASE + 32'd8, 32'h00FF_12AB);
        wr(BASE + 32'd8, 32'h9876_5432);
        check("hex_765432", 64'(hex_out), 64'(hex_model(24'h765432)));
        rd(BASE + 32'd10, 32'h0076_5432);
        wr(BASE + 32'd8, 32'h00FE_DCBA);
        check("hex_fedcba", 64'(hex_out), 64'(hex_model(24'hFEDCBA)));
        wr(BASE + 32'd8, 32'h0010_9810);
        check("hex_109810", 64'(hex_out), 64'(hex_model(24'h109810)));

        // Switch debounce: reads on edges 1..6 see 0, edge 7 sees the value
        sw_in = 10'b00_0010_0001;
        for (int i = 0; i < 6; i++) rd(BASE, 32'h0);
        rd(BASE, 32'h21);
        rd(BASE + 32'd12, 32'h1);
        rd(BASE + 32'd12, 32'h0);
        // 3-cycle glitch on sw_in[9] must be rejected
        sw_in = 10'h221;
        tick();
        tick();
        tick();
        sw_in = 10'h021;
        for (int i = 0; i < 8; i++) tick();
        rd(BASE, 32'h21);
        rd(BASE + 32'd12, 32'h0);

        // Collision: write wins, read dropped
        addr  = BASE + 32'd4;
        wdata = 32'h5;
        rd_en = 1'b1;
        wr_en = 1'b1;
        tick();
        rd_en = 1'b0;
        wr_en = 1'b0;
        check("collide_led", 64'(led_out), 64'(10'h5));
        check("collide_rvalid", 64'(rvalid), 64'(0));
        // STAT read on the acceptance edge returns the old flag
        sw_in = 10'h000;
        for (int i = 0; i < 5; i++) tick();
        rd(BASE + 32'd12, 32'h0);
        rd(BASE + 32'd12, 32'h1);
        rd(BASE, 32'h0);

        // Reset mid-operation
        sw_in = 10'h3FF;
        tick();
        tick();
        tick();
        addr  = BASE + 32'd4;
        wdata = 32'h7;
        wr_en = 1'b1;
        reset = 1'b1;
        tick();
        wr_en = 1'b0;
        reset = 1'b0;
        check("midreset_led", 64'(led_out), 64'(0));
        check("midreset_hex", 64'(hex_out), 64'(HEX_ZERO));
        for (int i = 0; i < 6; i++) rd(BASE, 32'h0);
        rd(BASE, 32'h3FF);
        rd(BASE + 32'd12, 32'h1);

        tick();
        tick();
        check("queue_drained", 64'(exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
